// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - 8-line vectored interrupt controller with IO-mapped MASK/VBASE/PEND/ISR registers
module irq_controller (
  input  logic        gclk1,
  input  logic        resetn,
  input  logic [19:0] A,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic        iorqn,
  input  logic        rdn,
  input  logic        wrn,
  input  logic        intan,
  input  logic [7:0]  irqn,
  output logic        intn,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_SERV} state_t;

  logic [1:0] rst_sync;
  logic       rst_n;
  logic [7:0] irq_s1, irq_s2, irq_d;
  logic [2:0] wr_sync, ia_sync;   // [0] first stage, [1] synchronised, [2] previous
  logic [7:0] pend, isr, mask;
  logic [4:0] vbase;
  logic [2:0] id, id_nxt, lowest;
  state_t     state, state_nxt;
  logic [7:0] irq_fall, req_vec, w1c_clr, ack_clr;
  logic       wr_commit, addr_hit, eoi, ia_rise, isr_set;

  // Reset asserts asynchronously but releases two edges later, aligned to gclk1
  always_ff @(posedge gclk1 or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge gclk1 or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1  <= 8'hFF;
      irq_s2  <= 8'hFF;
      irq_d   <= 8'hFF;
      wr_sync <= 3'b111;
      ia_sync <= 3'b111;
    end else begin
      irq_s1  <= irqn;
      irq_s2  <= irq_s1;
      irq_d   <= irq_s2;
      wr_sync <= {wr_sync[1:0], wrn};
      ia_sync <= {ia_sync[1:0], intan};
    end
  end

  assign irq_fall  = irq_d & ~irq_s2;
  assign ia_rise   = ia_sync[1] & ~ia_sync[2];
  assign addr_hit  = (A[19:2] == 18'h00008);
  assign wr_commit = wr_sync[2] & ~wr_sync[1] & ~iorqn & intan;
  assign eoi       = wr_commit & addr_hit & (A[1:0] == 2'd3);
  assign w1c_clr   = (wr_commit && addr_hit && A[1:0] == 2'd2) ? d_in : 8'h00;
  assign req_vec   = pend & ~mask;

  always_comb begin
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (req_vec[i]) lowest = i[2:0];
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    ack_clr   = 8'h00;
    isr_set   = 1'b0;
    case (state)
      S_IDLE: if (req_vec != 8'h00 && isr == 8'h00) begin
        state_nxt = S_REQ;
        id_nxt    = lowest;
      end
      // A request that loses its pending bit or gets masked before INTA is withdrawn
      S_REQ: begin
        if (!pend[id] || mask[id]) state_nxt = S_IDLE;
        else if (!ia_sync[1])      state_nxt = S_ACK;
      end
      S_ACK: if (ia_rise) begin
        state_nxt = S_SERV;
        ack_clr   = 8'h01 << id;
        isr_set   = 1'b1;
      end
      S_SERV: if (eoi) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge gclk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      id    <= 3'd0;
      pend  <= 8'h00;
      isr   <= 8'h00;
      mask  <= 8'hFF;
      vbase <= 5'd0;
    end else begin
      state <= state_nxt;
      id    <= id_nxt;
      // New edges win over any clear landing on the same cycle
      pend  <= (pend & ~(w1c_clr | ack_clr)) | irq_fall;
      if (isr_set)                    isr <= 8'h01 << id;
      else if (state == S_SERV && eoi) isr <= 8'h00;
      if (wr_commit && addr_hit && A[1:0] == 2'd0) mask  <= d_in;
      if (wr_commit && addr_hit && A[1:0] == 2'd1) vbase <= d_in[7:3];
    end
  end

  always_comb begin
    d_oe  = 1'b0;
    d_out = 8'h00;
    if (resetn) begin
      if (!intan && (state == S_REQ || state == S_ACK)) begin
        d_oe  = 1'b1;
        d_out = {vbase, id};
      end else if (!iorqn && !rdn && intan && addr_hit) begin
        d_oe = 1'b1;
        case (A[1:0])
          2'd0:    d_out = mask;
          2'd1:    d_out = {vbase, 3'b000};
          2'd2:    d_out = pend;
          default: d_out = isr;
        endcase
      end
    end
  end

  assign intn = ~(state == S_REQ || state == S_ACK);
  assign busy = (state != S_IDLE);

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 gclk1  in  1  sole clock; all state SHALL update on its rising edge.
REQ-002 resetn  in  1  reset SHALL be asynchronous and active-low; release is synchronised to gclk1.
REQ-003 A  in  20  bus address; only 0x00020-0x00023 SHALL be decoded, full 20-bit compare.
REQ-004 d_in  in  8  bus data from the CPU.
REQ-005 d_out  out  8  data driven to the bus, either a register value or the interrupt vector.
REQ-006 d_oe  out  1  tristate enable for d_out, active high; the top level SHALL drive d with d_out only when d_oe is 1.
REQ-007 iorqn, rdn, wrn, intan  in  1 each  bus strobes, all active-low.
REQ-008 irqn  in  8  interrupt request lines, active-low; irqn[0] has the highest priority.
REQ-009 intn  out  1  interrupt request to the CPU, active-low.
REQ-010 busy  out  1  high while state is not IDLE; drives led_o at the top level.

Function
REQ-011 Each irqn bit and wrn, intan SHALL pass through a 2-FF synchroniser; edge detection SHALL use the synchronised values.
REQ-012 A synchronised falling edge on irqn[i] SHALL set pend[i]; a held-low line SHALL NOT re-set the bit after it is cleared.
REQ-013 An IO write SHALL commit on the first gclk1 edge where synchronised wrn is 0 and was 1 on the previous cycle, iorqn=0 and intan=1; A and d_in SHALL be sampled raw on that edge.
REQ-014 0x00020 MASK: read/write; bit=1 masks irq i; reset value 0xFF.
REQ-015 0x00021 VBASE: read/write bits[7:3]; bits[2:0] SHALL read 0; reset value 0x00.
REQ-016 0x00022 PEND: read returns pend; a write clears each bit where d_in=1 (write-1-to-clear).
REQ-017 0x00023 ISR: read returns the one-hot in-service register; any write is EOI.
REQ-018 IO read: d_oe=1 and d_out=register combinationally while iorqn=0, rdn=0, intan=1 and A decodes; otherwise d_oe=0 for IO cycles.
REQ-019 The FSM SHALL have four states: IDLE, REQ, ACK, SERV; reset state is IDLE.
REQ-020 IDLE->REQ when (pend & ~MASK)!=0 and isr==0; id latches the lowest set index; intn=0 from the next cycle.
REQ-021 REQ: intn=0 and id is frozen with no preemption. If pend[id] becomes masked or cleared before an acknowledge, the FSM SHALL return to IDLE with intn=1 (withdrawn request).
REQ-022 REQ->ACK when synchronised intan=0.
REQ-023 d_oe=1 and d_out={VBASE[7:3],id} combinationally whenever intan=0 and state is REQ or ACK.
REQ-024 ACK->SERV on synchronised intan rising. On that transition: intn=1, pend[id] cleared, isr[id] set.
REQ-025 SERV->IDLE on EOI; isr is cleared. A new request may be raised from the cycle after.
REQ-026 EOI in IDLE, REQ or ACK SHALL be ignored.
REQ-027 An edge on irqn[id] on the same cycle its pend bit is cleared SHALL win: the bit stays set.
REQ-028 A W1C write and an ACK->SERV clear on the same cycle SHALL both apply, as a bitwise OR of the clears.
REQ-029 With intan=0 in IDLE or SERV, d_oe SHALL be 0.
REQ-030 busy = (state!=IDLE).

Reset
REQ-031 While resetn=0, outputs SHALL be: intn=1, d_oe=0, d_out=0x00, busy=0.
REQ-032 While resetn=0, registers SHALL be: pend=0x00, isr=0x00, MASK=0xFF, VBASE=0x00, id=0, state IDLE; synchronisers are loaded with 1.
REQ-033 Reset asserted in any state, including mid-ACK, SHALL abort immediately; no vector is driven and no isr bit is set.

Verification
REQ-034 Write MASK=0xFE, VBASE=0x40; pulse irqn[0] low -> intn=0 within 4 cycles. During intan low: d_oe=1, d=0x40. After intan high: ISR reads 0x01, PEND reads 0x00, intn=1.
REQ-035 MASK=0x00; irqn[5] and irqn[2] fall on the same cycle -> vector 0x42 (VBASE 0x40). Without EOI, no second intn. After EOI, a second acknowledge returns vector 0x45.
REQ-036 MASK=0xFF; irqn[3] falls -> PEND=0x08 and intn stays 1. Write MASK=0xF7 -> intn=0 with vector id 3.
REQ-037 In REQ with id=1, write MASK=0x02 before intan -> intn returns to 1 and state is IDLE; PEND still reads 0x02.
REQ-038 Assert resetn low during ACK with intan low -> d_oe=0 and intn=1 at once. After release: MASK=0xFF, PEND=0x00, ISR=0x00.
REQ-039 Write PEND=0xFF while in IDLE with pend=0x81 -> PEND=0x00 and no intn; an EOI write in IDLE leaves state unchanged.
